// File: rtl/alu_sched_if.sv
// alu_sched_if: request, shared-ALU and response signals of the alu_sched block.
// Handshake: a response transfers on a rising clk edge where rsp_valid && rsp_ready;
// once rsp_valid is high, rsp_data/rsp_flag/rsp_err/rsp_id stay stable until that transfer.
// The slave modport is the scheduler; the master modport is its environment.
interface alu_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_in1;
    logic [4*NUM_REQ-1:0] req_in2;
    logic [3*NUM_REQ-1:0] req_sel;
    logic [NUM_REQ-1:0]   req_grant;
    logic [3:0]           alu_in1;
    logic [3:0]           alu_in2;
    logic [2:0]           alu_select;
    logic [3:0]           alu_and;
    logic [3:0]           alu_or;
    logic [3:0]           alu_sum;
    logic [3:0]           alu_sub;
    logic [3:0]           alu_xor;
    logic                 alu_carry;
    logic                 alu_borrow;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [3:0]           rsp_data;
    logic                 rsp_flag;
    logic                 rsp_err;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
    logic [7:0]           op_count;
    logic [1:0]           dbg_state;

    modport slave (
        input  req_valid, req_in1, req_in2, req_sel,
        input  alu_and, alu_or, alu_sum, alu_sub, alu_xor, alu_carry, alu_borrow,
        input  rsp_ready,
        output req_grant, alu_in1, alu_in2, alu_select,
        output rsp_valid, rsp_data, rsp_flag, rsp_err, rsp_id,
        output busy, op_count, dbg_state
    );

    modport master (
        output req_valid, req_in1, req_in2, req_sel,
        output alu_and, alu_or, alu_sum, alu_sub, alu_xor, alu_carry, alu_borrow,
        output rsp_ready,
        input  req_grant, alu_in1, alu_in2, alu_select,
        input  rsp_valid, rsp_data, rsp_flag, rsp_err, rsp_id,
        input  busy, op_count, dbg_state
    );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational 4-bit ALU among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate, grant, register operands) ->
// EXEC (capture the selected ALU result) -> RESP (hold response until accepted).
// Optional macro ALU_SCHED_FIXED_PRIO_EN: lowest-index-wins arbitration, no rr_ptr.
// dbg_state exposes the FSM state encoding (0 IDLE, 1 EXEC, 2 RESP).
module alu_sched #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 2
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           found;
    logic [IDW-1:0] pick;
    logic [3:0]     pick_in1;
    logic [3:0]     pick_in2;
    logic [2:0]     pick_sel;
    logic [IDW-1:0] win_idx;
    logic           do_grant;
    logic           do_capture;
    logic           do_accept;
    logic [3:0]     res_data;
    logic           res_flag;
    logic           res_err;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;

    // Arbiter: choose the winning requester and route its operands.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_in1 = '0;
        pick_in2 = '0;
        pick_sel = '0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        // Scan downward so the lowest valid index is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                found    = 1'b1;
                pick     = IDW'(k);
                pick_in1 = bus.req_in1[4*k +: 4];
                pick_in2 = bus.req_in2[4*k +: 4];
                pick_sel = bus.req_sel[3*k +: 3];
            end
        end
`else
        // Scan upward from rr_ptr, wrapping at NUM_REQ; first valid wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = k + int'(rr_ptr);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                pick     = IDW'(idx);
                pick_in1 = bus.req_in1[4*idx +: 4];
                pick_in2 = bus.req_in2[4*idx +: 4];
                pick_sel = bus.req_sel[3*idx +: 3];
            end
        end
`endif
    end

    // Result mux: fold the ALU's per-operation outputs by the registered opcode.
    always_comb begin
        res_data = 4'd0;
        res_flag = 1'b0;
        res_err  = 1'b0;
        case (bus.alu_select)
            3'b000:  begin res_data = bus.alu_sum; res_flag = bus.alu_carry;  end
            3'b001:  begin res_data = bus.alu_sub; res_flag = bus.alu_borrow; end
            3'b010:  res_data = bus.alu_and;
            3'b011:  res_data = bus.alu_or;
            3'b100:  res_data = bus.alu_xor;
            default: res_err  = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and one-cycle action strobes.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_accept  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    do_grant  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                do_capture = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                if (bus.rsp_valid && bus.rsp_ready) begin
                    do_accept = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant pulse, ALU operand registers, response registers, counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.req_grant  <= '0;
            bus.alu_in1    <= '0;
            bus.alu_in2    <= '0;
            bus.alu_select <= '0;
            win_idx        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_flag   <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_id     <= '0;
            bus.op_count   <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            rr_ptr         <= '0;
`endif
        end else begin
            bus.req_grant <= '0;
            if (do_grant) begin
                bus.req_grant  <= NUM_REQ'(1) << pick;
                bus.alu_in1    <= pick_in1;
                bus.alu_in2    <= pick_in2;
                bus.alu_select <= pick_sel;
                win_idx        <= pick;
            end
            if (do_capture) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= res_data;
                bus.rsp_flag  <= res_flag;
                bus.rsp_err   <= res_err;
                bus.rsp_id    <= win_idx;
            end
            if (do_accept) begin
                bus.rsp_valid <= 1'b0;
                bus.op_count  <= bus.op_count + 8'd1;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a transaction-level model.
// The model predicts grants by scanning requesters from a pointer and predicts
// responses with plain arithmetic; one negedge process compares every cycle.
module tb_alu_sched;
    localparam int NUM_REQ = 2;
    localparam int IDW     = 2;
    localparam int RW      = IDW + 6;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_sched_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();
    alu_sched #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference ALU feeding the DUT.
    always_comb begin
        bus.alu_and = bus.alu_in1 & bus.alu_in2;
        bus.alu_or  = bus.alu_in1 | bus.alu_in2;
        bus.alu_xor = bus.alu_in1 ^ bus.alu_in2;
        {bus.alu_carry, bus.alu_sum} = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        bus.alu_sub    = bus.alu_in1 - bus.alu_in2;
        bus.alu_borrow = (bus.alu_in1 < bus.alu_in2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int pick_winner(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef ALU_SCHED_FIXED_PRIO_EN
        if (ptr < 0) return -1;
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`else
        for (int k = 0; k < NUM_REQ; k++) if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`endif
        return -1;
    endfunction

    // Packed prediction {id, err, flag, data}.
    function automatic logic [RW-1:0] predict(input int id, input int a, input int b, input int s);
        int d;
        bit f;
        bit e;
        d = 0; f = 0; e = 0;
        case (s)
            0: begin d = (a + b) % 16;      f = (a + b) > 15; end
            1: begin d = (a - b + 16) % 16; f = (a < b);      end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            default: e = 1;
        endcase
        return {IDW'(id), e, f, 4'(d)};
    endfunction

    logic [NUM_REQ-1:0] m_grant;
    logic [3:0]         m_in1, m_in2;
    logic [2:0]         m_sel;
    logic               m_busy, m_rsp_valid;
    logic [7:0]         m_count;
    int                 m_ptr, m_last, m_w;
    logic [RW-1:0]      exp_q[$];

    always_comb m_w = pick_winner(bus.req_valid, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grant <= '0; m_in1 <= '0; m_in2 <= '0; m_sel <= '0;
            m_busy <= 1'b0; m_rsp_valid <= 1'b0; m_count <= '0;
            m_ptr <= 0; m_last <= 0;
            exp_q.delete();
        end else begin
            m_grant <= '0;
            if (!m_busy) begin
                if (m_w >= 0) begin
                    m_grant <= NUM_REQ'(1) << m_w;
                    m_in1   <= bus.req_in1[4*m_w +: 4];
                    m_in2   <= bus.req_in2[4*m_w +: 4];
                    m_sel   <= bus.req_sel[3*m_w +: 3];
                    m_busy  <= 1'b1;
                    m_last  <= m_w;
                    exp_q.push_back(predict(m_w, int'(bus.req_in1[4*m_w +: 4]),
                        int'(bus.req_in2[4*m_w +: 4]), int'(bus.req_sel[3*m_w +: 3])));
                end
            end else if (!m_rsp_valid) begin
                m_rsp_valid <= 1'b1;
            end else if (bus.rsp_ready) begin
                m_rsp_valid <= 1'b0;
                m_busy      <= 1'b0;
                m_count     <= m_count + 8'd1;
                m_ptr       <= (m_last + 1) % NUM_REQ;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("grant", 32'(bus.req_grant), 32'(m_grant));
            check("alu_in1", 32'(bus.alu_in1), 32'(m_in1));
            check("alu_in2", 32'(bus.alu_in2), 32'(m_in2));
            check("alu_select", 32'(bus.alu_select), 32'(m_sel));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
            check("op_count", 32'(bus.op_count), 32'(m_count));
            if (m_rsp_valid && exp_q.size() > 0)
                check("rsp_fields", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_flag, bus.rsp_data}),
                      32'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bus.req_in1[4*i +: 4] = a;
        bus.req_in2[4*i +: 4] = b;
        bus.req_sel[3*i +: 3] = s;
        bus.req_valid[i]      = 1'b1;
    endtask

    // Waits for req_grant[i]; reports the number of extra cycles taken.
    task automatic wait_grant(input int i, output int cyc, output bit got);
        got = 0;
        cyc = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (bus.req_grant[i]) begin
                got = 1;
                cyc = c;
            end
        end
        check("grant_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (!bus.busy) ok = 1;
            else tick();
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    // Full operation from an idle DUT with literal expected results.
    task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                          input logic [3:0] ed, input logic ef, input logic ee);
        int cyc;
        bit got;
        set_req(i, a, b, s);
        wait_grant(i, cyc, got);
        check("grant_latency", 32'(cyc), 32'd0);
        bus.req_valid[i] = 1'b0;
        tick();
        check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
        check("lit_data", 32'(bus.rsp_data), 32'(ed));
        check("lit_flag", 32'(bus.rsp_flag), 32'(ef));
        check("lit_err", 32'(bus.rsp_err), 32'(ee));
        check("lit_id", 32'(bus.rsp_id), 32'(i));
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    int gcyc[$];
    logic [NUM_REQ-1:0] gval[$];

    initial begin
        int cyc;
        bit got;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        check("rst_grant", 32'(bus.req_grant), 32'd0);
        check("rst_alu", 32'({bus.alu_in1, bus.alu_in2, bus.alu_select}), 32'd0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_flag, bus.rsp_err, bus.rsp_id}), 32'd0);
        check("rst_busy_cnt", 32'({bus.busy, bus.op_count}), 32'd0);
        rst = 1'b0;
        tick();

        // Single add and subtract with borrow.
        run_op(0, 4'd9, 4'd8, 3'b000, 4'd1, 1'b1, 1'b0);
        run_op(1, 4'd3, 4'd5, 3'b001, 4'b1110, 1'b1, 1'b0);
        check("count_after_two", 32'(bus.op_count), 32'd2);

        // Backpressure on an xor; a late request from req1 is withdrawn unserved.
        bus.rsp_ready = 1'b0;
        set_req(0, 4'hA, 4'h6, 3'b100);
        wait_grant(0, cyc, got);
        bus.req_valid[0] = 1'b0;
        tick();
        set_req(1, 4'd1, 4'd2, 3'b010);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_data", 32'(bus.rsp_data), 32'hC);
            check("bp_nogrant", 32'(bus.req_grant), 32'd0);
            if (c == 3) bus.req_valid[1] = 1'b0;
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_accepted", 32'(bus.rsp_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("withdrawn_nogrant", 32'(bus.req_grant), 32'd0);
        end
        check("count_after_bp", 32'(bus.op_count), 32'd3);

        // Illegal opcode.
        run_op(1, 4'd5, 4'd5, 3'b110, 4'd0, 1'b0, 1'b1);

        // Contention with both requesters held valid.
        set_req(0, 4'd1, 4'd2, 3'b000);
        set_req(1, 4'd7, 4'd7, 3'b011);
        for (int c = 0; c < 14; c++) begin
            tick();
            if (|bus.req_grant) begin
                gcyc.push_back(c);
                gval.push_back(bus.req_grant);
            end
        end
        bus.req_valid = '0;
        repeat (3) tick();
        wait_idle();
        check("cont_count", 32'(gval.size() >= 4), 32'd1);
        for (int k = 1; k < gval.size(); k++) begin
            check("cont_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
`ifdef ALU_SCHED_FIXED_PRIO_EN
            check("cont_fixed", 32'(gval[k]), 32'b01);
`else
            check("cont_alternate", 32'(gval[k] ^ gval[k-1]), 32'b11);
`endif
        end

        // Reset while a response is held.
        run_op(0, 4'd4, 4'd4, 3'b011, 4'd4, 1'b0, 1'b0);
        bus.rsp_ready = 1'b0;
        set_req(1, 4'd2, 4'd1, 3'b001);
        wait_grant(1, cyc, got);
        bus.req_valid[1] = 1'b0;
        tick();
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        set_req(0, 4'd6, 4'd3, 3'b000);
        set_req(1, 4'd8, 4'd8, 3'b000);
        rst = 1'b1;
        #1;
        check("arst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_flag, bus.rsp_err, bus.rsp_id}), 32'd0);
        check("arst_misc", 32'({bus.req_grant, bus.busy, bus.op_count}), 32'd0);
        check("arst_alu", 32'({bus.alu_in1, bus.alu_in2, bus.alu_select}), 32'd0);
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("post_rst_grant", 32'(bus.req_grant), 32'b01);
        bus.req_valid = '0;
        tick();
        check("post_rst_data", 32'(bus.rsp_data), 32'd9);
        wait_idle();
        check("post_rst_count", 32'(bus.op_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
